// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: resolves one control transfer at a time, redirecting and flushing fetch on a mispredict
module branch #(
    parameter int XLEN = 32
) (
    input  logic [4:0]      opcode_6_to_2_in,
    input  logic [2:0]      funct3_in,
    input  logic [XLEN-1:0] rs1_in,
    input  logic [XLEN-1:0] rs2_in,
    output logic            branch_taken_out
);
    logic cmp;
    always_comb begin
        cmp = funct3_in[2] ? (funct3_in[1] ? rs1_in < rs2_in : $signed(rs1_in) < $signed(rs2_in))
                           : rs1_in == rs2_in;
        branch_taken_out = opcode_6_to_2_in == 5'b11000 && (funct3_in[2] || !funct3_in[1])
                           && (cmp ^ funct3_in[0]);
    end
endmodule

module branch_resolve_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic [4:0]           opcode_6_to_2_in,
    input  logic [2:0]           funct3_in,
    input  logic [XLEN-1:0]      rs1_in,
    input  logic [XLEN-1:0]      rs2_in,
    input  logic [XLEN-1:0]      pc_in,
    input  logic [XLEN-1:0]      imm_in,
    input  logic                 pred_taken_in,
    input  logic [XLEN-1:0]      pred_target_in,
    input  logic                 redirect_ack_in,
    output logic                 resolved_out,
    output logic                 taken_out,
    output logic                 redirect_valid_out,
    output logic [XLEN-1:0]      redirect_pc_out,
    output logic                 flush_out,
    output logic [CNT_WIDTH-1:0] branch_count_out,
    output logic [CNT_WIDTH-1:0] mispredict_count_out
);
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    typedef enum logic [1:0] {IDLE, EVAL, REDIRECT, FLUSH} state_t;
    state_t               state_q, state_d;
    logic [4:0]           op_q, op_d;
    logic [2:0]           f3_q, f3_d;
    logic [XLEN-1:0]      rs1_q, rs1_d, rs2_q, rs2_d, pc_q, pc_d, imm_q, imm_d;
    logic [XLEN-1:0]      ptgt_q, ptgt_d, rpc_q, rpc_d;
    logic                 pt_q, pt_d, ready_q, ready_d, resolved_q, resolved_d;
    logic                 taken_q, taken_d, rv_q, rv_d, flush_q, flush_d;
    logic [3:0]           fcnt_q, fcnt_d;
    logic [CNT_WIDTH-1:0] bc_q, bc_d, mc_q, mc_d;
    logic                 idle, br_taken, known, act_taken, mispred;
    logic [4:0]           br_op;
    logic [2:0]           br_f3;
    logic [XLEN-1:0]      br_rs1, br_rs2, target;
    always_comb begin
        idle   = state_q == IDLE;
        br_op  = idle ? opcode_6_to_2_in : op_q;
        br_f3  = idle ? funct3_in : f3_q;
        br_rs1 = idle ? rs1_in : rs1_q;
        br_rs2 = idle ? rs2_in : rs2_q;
    end
    branch #(.XLEN(XLEN)) u_branch (
        .opcode_6_to_2_in(br_op),
        .funct3_in       (br_f3),
        .rs1_in          (br_rs1),
        .rs2_in          (br_rs2),
        .branch_taken_out(br_taken)
    );
    always_comb begin
        known      = br_op == OP_BRANCH || br_op == OP_JAL || br_op == OP_JALR;
        act_taken  = br_op == OP_BRANCH ? br_taken : known;
        target     = op_q == OP_JALR ? (rs1_q + imm_q) & ~XLEN'(1) : pc_q + imm_q;
        mispred    = known && (act_taken != pt_q || (act_taken && target != ptgt_q));
        state_d    = state_q;
        op_d       = op_q;
        f3_d       = f3_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        pc_d       = pc_q;
        imm_d      = imm_q;
        pt_d       = pt_q;
        ptgt_d     = ptgt_q;
        rpc_d      = rpc_q;
        fcnt_d     = fcnt_q;
        bc_d       = bc_q;
        mc_d       = mc_q;
        resolved_d = 1'b0;
        taken_d    = 1'b0;
        case (state_q)
            IDLE: if (valid_in) begin
                op_d       = opcode_6_to_2_in;
                f3_d       = funct3_in;
                rs1_d      = rs1_in;
                rs2_d      = rs2_in;
                pc_d       = pc_in;
                imm_d      = imm_in;
                pt_d       = pred_taken_in;
                ptgt_d     = pred_target_in;
                resolved_d = 1'b1;
                taken_d    = act_taken;
                state_d    = EVAL;
            end
            EVAL: begin
                if (known) bc_d = &bc_q ? bc_q : bc_q + CNT_WIDTH'(1);
                if (mispred) begin
                    rpc_d   = act_taken ? target : pc_q + XLEN'(4);
                    mc_d    = &mc_q ? mc_q : mc_q + CNT_WIDTH'(1);
                    state_d = REDIRECT;
                end else begin
                    state_d = IDLE;
                end
            end
            REDIRECT: if (redirect_ack_in) begin
                state_d = FLUSH;
                fcnt_d  = 4'(FLUSH_CYCLES);
            end
            FLUSH: begin
                fcnt_d = fcnt_q - 4'd1;
                if (fcnt_q == 4'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = state_d == IDLE;
        rv_d    = state_d == REDIRECT;
        flush_d = rv_d || state_d == FLUSH;
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            op_q       <= '0;
            f3_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            pc_q       <= '0;
            imm_q      <= '0;
            pt_q       <= 1'b0;
            ptgt_q     <= '0;
            rpc_q      <= '0;
            fcnt_q     <= '0;
            bc_q       <= '0;
            mc_q       <= '0;
            ready_q    <= 1'b1;
            resolved_q <= 1'b0;
            taken_q    <= 1'b0;
            rv_q       <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            f3_q       <= f3_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            pc_q       <= pc_d;
            imm_q      <= imm_d;
            pt_q       <= pt_d;
            ptgt_q     <= ptgt_d;
            rpc_q      <= rpc_d;
            fcnt_q     <= fcnt_d;
            bc_q       <= bc_d;
            mc_q       <= mc_d;
            ready_q    <= ready_d;
            resolved_q <= resolved_d;
            taken_q    <= taken_d;
            rv_q       <= rv_d;
            flush_q    <= flush_d;
        end
    end
    assign ready_out            = ready_q;
    assign resolved_out         = resolved_q;
    assign taken_out            = taken_q;
    assign redirect_valid_out   = rv_q;
    assign redirect_pc_out      = rpc_q;
    assign flush_out            = flush_q;
    assign branch_count_out     = bc_q;
    assign mispredict_count_out = mc_q;
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: randomized and directed checks against a cycle-timeline model of the controller
module tb_branch_resolve_ctrl;
    localparam int XLEN = 32;
    localparam int FC   = 2;
    localparam int CW   = 4;
    localparam int MAXC = 8192;
    localparam logic [4:0] OP_B    = 5'b11000;
    localparam logic [4:0] OP_JAL  = 5'b11011;
    localparam logic [4:0] OP_JALR = 5'b11001;

    logic clk = 0, rst = 1, valid = 0, pt = 0, ack = 0;
    logic [4:0] op = 0;
    logic [2:0] f3 = 0;
    logic [31:0] rs1 = 0, rs2 = 0, pc = 0, imm = 0, ptg = 0;
    logic ready, resolved, taken, rv, fl;
    logic [31:0] rpc;
    logic [CW-1:0] bc, mc;

    branch_resolve_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
        .clk_in(clk), .rst_in(rst), .valid_in(valid), .ready_out(ready),
        .opcode_6_to_2_in(op), .funct3_in(f3), .rs1_in(rs1), .rs2_in(rs2),
        .pc_in(pc), .imm_in(imm), .pred_taken_in(pt), .pred_target_in(ptg),
        .redirect_ack_in(ack), .resolved_out(resolved), .taken_out(taken),
        .redirect_valid_out(rv), .redirect_pc_out(rpc), .flush_out(fl),
        .branch_count_out(bc), .mispredict_count_out(mc)
    );

    always #5 clk = ~clk;

    // expected outputs for each cycle (cycle c = interval after the c-th rising edge)
    bit          touched[MAXC];
    bit          e_ready[MAXC], e_res[MAXC], e_tk[MAXC], e_rv[MAXC], e_fl[MAXC], ack_pat[MAXC];
    logic [31:0] e_pc[MAXC];
    int          e_bc[MAXC], e_mc[MAXC];
    int cyc = 0, acc_count = 0, acc_cyc = 0;
    bit armed = 0;
    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    function automatic bit cond(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] tgt_of(input logic [4:0] o, input logic [31:0] a, input logic [31:0] p, input logic [31:0] i);
        logic [31:0] s;
        s = a + i;
        s[0] = 1'b0;
        return o == OP_JALR ? s : p + i;
    endfunction

    function automatic int sat(input int x);
        return x < (1 << CW) - 1 ? x + 1 : x;
    endfunction

    always @(posedge clk) begin : mdl
        int c, a, r, nbc, nmc;
        bit tk, kn, mis;
        logic [31:0] tg, npc;
        cyc = cyc + 1;
        c = cyc;
        if (c < MAXC) begin
            if (rst) begin
                e_ready[c] = 1; e_res[c] = 0; e_tk[c] = 0; e_rv[c] = 0; e_fl[c] = 0;
                e_pc[c] = 0; e_bc[c] = 0; e_mc[c] = 0; touched[c] = 1;
                for (int k = c + 1; k < MAXC; k++) touched[k] = 0;
                armed = 1;
            end else if (armed) begin
                if (valid && e_ready[c-1]) begin
                    kn  = op == OP_B || op == OP_JAL || op == OP_JALR;
                    tk  = op == OP_B ? cond(f3, rs1, rs2) : kn;
                    tg  = tgt_of(op, rs1, pc, imm);
                    mis = kn && (tk != pt || (tk && tg != ptg));
                    npc = mis ? (tk ? tg : pc + 4) : e_pc[c-1];
                    nbc = kn ? sat(e_bc[c-1]) : e_bc[c-1];
                    nmc = mis ? sat(e_mc[c-1]) : e_mc[c-1];
                    e_ready[c] = 0; e_res[c] = 1; e_tk[c] = tk; e_rv[c] = 0; e_fl[c] = 0;
                    e_pc[c] = e_pc[c-1]; e_bc[c] = e_bc[c-1]; e_mc[c] = e_mc[c-1]; touched[c] = 1;
                    r = c + 1;
                    if (mis) begin
                        a = c + 1;
                        while (a < MAXC - 1 && !ack_pat[a]) a++;
                        for (int k = c + 1; k <= a + FC && k < MAXC; k++) begin
                            e_ready[k] = 0; e_res[k] = 0; e_tk[k] = 0;
                            e_rv[k] = k <= a; e_fl[k] = 1;
                        end
                        r = a + FC + 1;
                    end
                    if (r < MAXC) begin
                        e_ready[r] = 1; e_res[r] = 0; e_tk[r] = 0; e_rv[r] = 0; e_fl[r] = 0;
                    end
                    for (int k = c + 1; k <= r && k < MAXC; k++) begin
                        e_pc[k] = npc; e_bc[k] = nbc; e_mc[k] = nmc; touched[k] = 1;
                    end
                    acc_count++;
                    acc_cyc = c;
                end
                if (!touched[c]) begin
                    e_ready[c] = 1; e_res[c] = 0; e_tk[c] = 0; e_rv[c] = 0; e_fl[c] = 0;
                    e_pc[c] = e_pc[c-1]; e_bc[c] = e_bc[c-1]; e_mc[c] = e_mc[c-1]; touched[c] = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed && cyc < MAXC) begin
            chk("ready", ready, e_ready[cyc]);
            chk("resolved", resolved, e_res[cyc]);
            chk("taken", taken, e_tk[cyc]);
            chk("redirect_valid", rv, e_rv[cyc]);
            chk("flush", fl, e_fl[cyc]);
            chk("redirect_pc", rpc, e_pc[cyc]);
            chk("branch_count", bc, e_bc[cyc]);
            chk("mispredict_count", mc, e_mc[cyc]);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            ack = cyc < MAXC ? ack_pat[cyc] : 1'b0;
        end
    end

    initial begin
        #(MAXC * 10);
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_cyc(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic send(input logic [4:0] o, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] i, input logic t, input logic [31:0] g,
                        input int ad, output int e);
        int n;
        @(negedge clk);
        if (ad >= 0) for (int w = 0; w < 200 && !e_ready[cyc]; w++) @(negedge clk);
        op = o; f3 = f; rs1 = a; rs2 = b; pc = p; imm = i; pt = t; ptg = g; valid = 1;
        if (ad >= 0) begin
            for (int k = cyc + 2; k < cyc + 2 + ad && k < MAXC; k++) ack_pat[k] = 0;
            if (cyc + 2 + ad < MAXC) ack_pat[cyc + 2 + ad] = 1;
        end
        n = acc_count;
        e = -1;
        for (int w = 0; w < 300 && e < 0; w++) begin
            @(negedge clk);
            if (acc_count != n) e = acc_cyc;
        end
        valid = 0;
        op = 5'($urandom); f3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
        pc = $urandom; imm = $urandom; pt = 1'($urandom); ptg = $urandom;
        if (e < 0) begin
            chk("accept_timeout", 0, 1);
            e = cyc;
        end
    endtask

    initial begin
        int e, sel;
        logic [4:0] ro;
        logic [31:0] ra, rb, rp, ri, r12;
        logic rt;
        for (int i = 0; i < MAXC; i++) ack_pat[i] = $urandom_range(0, 2) == 0;
        rst = 1; valid = 1; op = OP_JAL; pc = 32'h80; imm = 32'h10;
        repeat (2) @(negedge clk);
        rst = 0; valid = 0;
        @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_rv", rv, 0);
        chk("rst_flush", fl, 0);
        chk("rst_pc", rpc, 0);
        chk("rst_bc", bc, 0);

        send(OP_B, 3'd0, 32'h1, 32'h1, 32'h100, 32'h20, 1, 32'h120, -1, e);
        wait_cyc(e);
        chk("beq_resolved", resolved, 1);
        chk("beq_taken", taken, 1);
        chk("beq_model_taken", e_tk[e], 1);
        wait_cyc(e + 1);
        chk("beq_bc", bc, 1);
        chk("beq_mc", mc, 0);
        chk("beq_no_redirect", rv, 0);

        send(OP_B, 3'd4, 32'hFFFF_FFFE, 32'h2, 32'h200, 32'h40, 0, 32'h0, 3, e);
        wait_cyc(e + 1);
        chk("blt_rv", rv, 1);
        chk("blt_pc", rpc, 32'h240);
        chk("blt_model_pc", e_pc[e + 1], 32'h240);
        chk("blt_mc", mc, 1);
        wait_cyc(e + 4);
        chk("blt_pc_held", rpc, 32'h240);
        chk("blt_rv_held", rv, 1);
        wait_cyc(e + 5);
        chk("blt_flush1_rv", rv, 0);
        chk("blt_flush1", fl, 1);
        wait_cyc(e + 6);
        chk("blt_flush2", fl, 1);
        wait_cyc(e + 7);
        chk("blt_flush_end", fl, 0);
        chk("blt_ready", ready, 1);

        send(OP_B, 3'd7, 32'h1, 32'hFFFF_FFFF, 32'h300, 32'h10, 1, 32'h310, 0, e);
        wait_cyc(e + 1);
        chk("bgeu_taken_pulse", e_tk[e], 0);
        chk("bgeu_rv", rv, 1);
        chk("bgeu_pc", rpc, 32'h304);

        send(OP_JALR, 3'd0, 32'h1001, 32'h0, 32'h400, 32'h4, 1, 32'h1004, 0, e);
        wait_cyc(e + 1);
        chk("jalr_ok_rv", rv, 0);
        chk("jalr_ok_ready", ready, 1);

        send(OP_JALR, 3'd0, 32'h1001, 32'h0, 32'h400, 32'h4, 1, 32'h1000, 0, e);
        wait_cyc(e + 1);
        chk("jalr_bad_rv", rv, 1);
        chk("jalr_bad_pc", rpc, 32'h1004);

        send(OP_JAL, 3'd0, 32'h0, 32'h0, 32'h500, 32'h8, 0, 32'h0, 20, e);
        wait_cyc(e + 2);
        chk("pre_rst_rv", rv, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst_redir_rv", rv, 0);
        chk("rst_redir_flush", fl, 0);
        chk("rst_redir_bc", bc, 0);
        chk("rst_redir_mc", mc, 0);

        for (int n = 0; n < 17; n++) send(OP_JAL, 3'd0, 32'h0, 32'h0, 32'h600, 32'h10, 0, 32'h0, 0, e);
        wait_cyc(e + 1);
        chk("sat_bc", bc, 15);
        chk("sat_mc", mc, 15);
        chk("sat_model_bc", e_bc[e + 1], 15);

        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        for (int t = 0; t < 500 && cyc < MAXC - 400; t++) begin
            if ($urandom_range(0, 24) == 0) begin
                @(negedge clk);
                rst = 1;
                @(negedge clk);
                rst = 0;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            sel = $urandom_range(0, 9);
            ro = sel < 5 ? OP_B : sel < 7 ? OP_JAL : sel < 9 ? OP_JALR : 5'($urandom);
            if (sel == 9 && (ro == OP_B || ro == OP_JAL || ro == OP_JALR)) ro = 5'b01100;
            ra = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
            rb = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) rb = ra;
            rp = $urandom & 32'hFFFF_FFFC;
            r12 = $urandom;
            ri = $urandom_range(0, 1) ? r12 : {{20{r12[11]}}, r12[11:0]};
            rt = 1'($urandom);
            send(ro, 3'($urandom), ra, rb, rp, ri, rt,
                 $urandom_range(0, 1) ? tgt_of(ro, ra, rp, ri) : $urandom, -1, e);
        end
        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
